// File: rtl/coherence_pkg.sv
// Shared coherence types for the snoop-bus arbiter: end states, bus word type,
// default block size and the arbiter FSM state encoding.
package coherence_pkg;

   localparam int unsigned DEFAULT_BLOCK_SIZE = 2;

   typedef logic [31:0] word_t;

   // Final state handed to the requesting cache; MODIFIED doubles as the reset value
   typedef enum logic [1:0] {
      MODIFIED  = 2'd0,
      EXCLUSIVE = 2'd1,
      SHARED    = 2'd2,
      INVALID   = 2'd3
   } cc_end_state;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StSnoop = 3'd1,
      StWb    = 3'd2,
      StMemRd = 3'd3,
      StDone  = 3'd4
   } arb_state_e;

   // Width of a word index within a block, never less than one bit
   function automatic int unsigned idx_width(input int unsigned block_size);
      return (block_size > 1) ? $clog2(block_size) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the lowest requester at or after the
// pointer; the pointer moves past the winner only when advance is asserted.
module rr_arbiter #(
   parameter int unsigned N = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int unsigned PTR_W = (N > 1) ? $clog2(N) : 1;

   logic [PTR_W-1:0] ptr_q, ptr_d;

   // Search N positions starting at the pointer, wrapping at N
   always_comb begin
      int unsigned      j;
      logic [PTR_W-1:0] jj;
      logic             found;
      j     = 0;
      jj    = '0;
      found = 1'b0;
      grant = '0;
      ptr_d = ptr_q;
      for (int unsigned k = 0; k < N; k++) begin
         j = 32'(ptr_q) + k;
         if (j >= N) j = j - N;
         jj = PTR_W'(j);
         if (!found && req[jj]) begin
            found     = 1'b1;
            grant[jj] = 1'b1;
            if (advance) ptr_d = (j == N - 1) ? '0 : PTR_W'(j + 1);
         end
      end
   end

   // Pointer register
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/mesi_snoop_arbiter.sv
// MESI snoop-bus arbiter: grants one L1 miss at a time, snoops the other caches,
// writes back a dirty owner's block, then returns the block to the requester.
// Optional feature macro CACHE_TO_CACHE_EN: the dirty owner's writeback data is
// also forwarded to the requester and the memory refetch is skipped.
module mesi_snoop_arbiter
   import coherence_pkg::*;
#(
   parameter int unsigned  N_CACHES   = 2,
   parameter int unsigned  BLOCK_SIZE = DEFAULT_BLOCK_SIZE,
   localparam int unsigned IDX_W      = idx_width(BLOCK_SIZE)
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic [N_CACHES-1:0]        req_valid,
   input  logic [N_CACHES-1:0]        req_write,
   input  logic [N_CACHES-1:0][31:0]  req_addr,
   output logic [N_CACHES-1:0]        grant,
   output logic                       resp_valid,
   output logic [31:0]                resp_data,
   output logic [IDX_W-1:0]           resp_idx,
   output logic                       resp_done,
   output cc_end_state                resp_state,
   output logic [N_CACHES-1:0]        snoop_req,
   output logic [31:0]                snoop_addr,
   output logic                       snoop_inv,
   output logic [IDX_W-1:0]           snoop_idx,
   input  logic [N_CACHES-1:0]        snoop_hit,
   input  logic [N_CACHES-1:0]        snoop_dirty,
   input  logic [N_CACHES-1:0][31:0]  snoop_data,
   output logic                       mem_ren,
   output logic                       mem_wen,
   output logic [31:0]                mem_addr,
   output logic [31:0]                mem_wdata,
   input  logic [31:0]                mem_rdata,
   input  logic                       mem_ready
);

   localparam int unsigned OWN_W = $clog2(N_CACHES);

   arb_state_e          state_q, state_d;
   logic [N_CACHES-1:0] grant_q, grant_d;
   word_t               addr_q, addr_d;
   logic                write_q, write_d;
   logic [OWN_W-1:0]    owner_q, owner_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   cc_end_state         end_q, end_d;

   logic [N_CACHES-1:0] arb_grant;
   logic                arb_advance;
   logic [OWN_W-1:0]    req_sel;
   logic [OWN_W-1:0]    dirty_sel;
   logic [N_CACHES-1:0] others, dirty_o, hit_o;
   logic                last_word;
   word_t               word_addr;

   rr_arbiter #(
      .N (N_CACHES)
   ) u_rr_arbiter (
      .clk     (CLK),
      .rst     (RST),
      .req     (req_valid),
      .advance (arb_advance),
      .grant   (arb_grant)
   );

   // Snoop responses from everyone but the requester; a dirty copy is also a hit
   assign others    = ~grant_q;
   assign dirty_o   = snoop_dirty & others;
   assign hit_o     = (snoop_hit | snoop_dirty) & others;
   assign last_word = (idx_q == IDX_W'(BLOCK_SIZE - 1));
   assign word_addr = addr_q + (32'(idx_q) << 2);

   // One-hot to index for the new grant, and lowest-index dirty owner
   always_comb begin
      req_sel   = '0;
      dirty_sel = '0;
      for (int i = int'(N_CACHES) - 1; i >= 0; i--) begin
         if (arb_grant[i]) req_sel = OWN_W'(i);
         if (dirty_o[i])   dirty_sel = OWN_W'(i);
      end
   end

   // Next-state and output decode
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      addr_d      = addr_q;
      write_d     = write_q;
      owner_d     = owner_q;
      idx_d       = idx_q;
      end_d       = end_q;
      arb_advance = 1'b0;
      resp_valid  = 1'b0;
      resp_data   = '0;
      resp_idx    = '0;
      resp_done   = 1'b0;
      snoop_req   = '0;
      snoop_addr  = '0;
      snoop_inv   = 1'b0;
      snoop_idx   = '0;
      mem_ren     = 1'b0;
      mem_wen     = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;

      unique case (state_q)
         StIdle: begin
            if (|req_valid) begin
               arb_advance = 1'b1;
               grant_d     = arb_grant;
               addr_d      = req_addr[req_sel];
               write_d     = req_write[req_sel];
               state_d     = StSnoop;
            end
         end
         StSnoop: begin
            snoop_req  = others;
            snoop_addr = addr_q;
            snoop_inv  = write_q;
            idx_d      = '0;
            end_d      = write_q ? MODIFIED : ((|hit_o) ? SHARED : EXCLUSIVE);
            if (|dirty_o) begin
               owner_d = dirty_sel;
               state_d = StWb;
            end else begin
               state_d = StMemRd;
            end
         end
         StWb: begin
            mem_wen            = 1'b1;
            mem_addr           = word_addr;
            mem_wdata          = snoop_data[owner_q];
            snoop_req[owner_q] = 1'b1;
            snoop_addr         = addr_q;
            snoop_idx          = idx_q;
`ifdef CACHE_TO_CACHE_EN
            if (mem_ready) begin
               resp_valid = 1'b1;
               resp_data  = snoop_data[owner_q];
               resp_idx   = idx_q;
            end
`endif
            if (mem_ready) begin
               if (last_word) begin
                  idx_d = '0;
`ifdef CACHE_TO_CACHE_EN
                  state_d = StDone;
`else
                  state_d = StMemRd;
`endif
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         StMemRd: begin
            mem_ren  = 1'b1;
            mem_addr = word_addr;
            if (mem_ready) begin
               resp_valid = 1'b1;
               resp_data  = mem_rdata;
               resp_idx   = idx_q;
               if (last_word) begin
                  idx_d   = '0;
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         StDone: begin
            resp_done = 1'b1;
            grant_d   = '0;
            state_d   = StIdle;
         end
         default: begin
            grant_d = '0;
            idx_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   assign grant      = grant_q;
   assign resp_state = end_q;

   // State registers; reset drops any transaction in flight
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         grant_q <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         owner_q <= '0;
         idx_q   <= '0;
         end_q   <= MODIFIED;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         owner_q <= owner_d;
         idx_q   <= idx_d;
         end_q   <= end_d;
      end
   end

endmodule

// File: tb/tb_mesi_snoop_arbiter.sv
// Directed bench for mesi_snoop_arbiter with four caches and two-word blocks:
// per-cycle vector table for single transactions, then hand sequences for
// reset mid-transaction and round-robin fairness.
module tb_mesi_snoop_arbiter;
   import coherence_pkg::*;

   logic             clk = 1'b0;
   logic             RST;
   logic [3:0]       req_valid, req_write;
   logic [3:0][31:0] req_addr;
   logic [3:0]       grant;
   logic             resp_valid, resp_done;
   logic [31:0]      resp_data;
   logic [0:0]       resp_idx, snoop_idx;
   cc_end_state      resp_state;
   logic [3:0]       snoop_req, snoop_hit, snoop_dirty;
   logic [31:0]      snoop_addr;
   logic             snoop_inv;
   logic [3:0][31:0] snoop_data;
   logic             mem_ren, mem_wen, mem_ready;
   logic [31:0]      mem_addr, mem_wdata, mem_rdata;

   int total = 0;
   int bad   = 0;

   mesi_snoop_arbiter #(
      .N_CACHES   (4),
      .BLOCK_SIZE (2)
   ) dut (
      .CLK         (clk),
      .RST         (RST),
      .req_valid   (req_valid),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .grant       (grant),
      .resp_valid  (resp_valid),
      .resp_data   (resp_data),
      .resp_idx    (resp_idx),
      .resp_done   (resp_done),
      .resp_state  (resp_state),
      .snoop_req   (snoop_req),
      .snoop_addr  (snoop_addr),
      .snoop_inv   (snoop_inv),
      .snoop_idx   (snoop_idx),
      .snoop_hit   (snoop_hit),
      .snoop_dirty (snoop_dirty),
      .snoop_data  (snoop_data),
      .mem_ren     (mem_ren),
      .mem_wen     (mem_wen),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready)
   );

   always #5 clk = ~clk;

   // Memory returns address + 0x1000_0000; caches return fixed per-word data
   assign mem_rdata = mem_addr + 32'h1000_0000;
   always_comb begin
      snoop_data[0] = 32'h0C00_0000 | 32'(snoop_idx);
      snoop_data[1] = snoop_idx[0] ? 32'h0000_BBBB : 32'h0000_AAAA;
      snoop_data[2] = 32'h2222_0000;
      snoop_data[3] = 32'hDEAD_0000 | 32'(snoop_idx);
   end

   typedef struct {
      logic [3:0]  rv, rw, hit, dirty;
      logic        rdy;
      logic [31:0] a0;
      logic [3:0]  grant, sreq;
      logic        sinv, ren, wen;
      logic [31:0] maddr, wdata;
      logic        rvalid;
      logic [31:0] rdata;
      logic        done;
      logic [1:0]  st;
      logic [31:0] saddr;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(
      input logic [3:0] rv, rw, hit, dirty, input logic rdy, input logic [31:0] a0,
      input logic [3:0] g, sreq, input logic sinv, ren, wen,
      input logic [31:0] maddr, wdata, input logic rvalid, input logic [31:0] rdata,
      input logic done, input logic [1:0] st, input logic [31:0] saddr);
      vec_t v;
      v.rv = rv; v.rw = rw; v.hit = hit; v.dirty = dirty; v.rdy = rdy; v.a0 = a0;
      v.grant = g; v.sreq = sreq; v.sinv = sinv; v.ren = ren; v.wen = wen;
      v.maddr = maddr; v.wdata = wdata; v.rvalid = rvalid; v.rdata = rdata;
      v.done = done; v.st = st; v.saddr = saddr;
      return v;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string name);
      check({name, "_ctl"}, {grant, resp_valid, resp_done, resp_state, resp_idx, snoop_req,
            snoop_inv, snoop_idx, mem_ren, mem_wen}, '0);
      check({name, "_dat"}, {resp_data, snoop_addr, mem_addr, mem_wdata}, '0);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          words;
      bit          seen;
      logic [3:0]  exp_g;

      RST = 1'b1; req_valid = '0; req_write = '0; snoop_hit = '0; snoop_dirty = '0;
      mem_ready = 1'b0;
      req_addr[0] = 32'h100; req_addr[1] = 32'h200;
      req_addr[2] = 32'h400; req_addr[3] = 32'h500;

      // Read miss, no sharers: cache 0 @0x100, drops req_valid after grant
      vecs.push_back(mk(4'h1, 0, 0, 0, 1, 32'h100,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,
                        4'h1, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,
                        4'h1, 0, 0, 1, 0, 32'h100, 0, 1, 32'h1000_0100, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,
                        4'h1, 0, 0, 1, 0, 32'h104, 0, 1, 32'h1000_0104, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,
                        4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 1, EXCLUSIVE, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // Write miss by cache 1 @0x200, cache 0 clean hit, one wait state
      vecs.push_back(mk(4'h2, 4'h2, 0, 0, 0, 32'h100,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'h1, 0, 0, 32'h100,
                        4'h2, 4'hD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200));
      vecs.push_back(mk(0, 0, 0, 0, 0, 32'h100,
                        4'h2, 0, 0, 1, 0, 32'h200, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,
                        4'h2, 0, 0, 1, 0, 32'h200, 0, 1, 32'h1000_0200, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,
                        4'h2, 0, 0, 1, 0, 32'h204, 0, 1, 32'h1000_0204, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,
                        4'h2, 0, 0, 0, 0, 0, 0, 0, 0, 1, MODIFIED, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h100,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      // Read by cache 0 @0x300; caches 1 and 3 dirty (and requester's own, ignored)
      vecs.push_back(mk(4'h1, 0, 0, 0, 1, 32'h300,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 4'hB, 4'hB, 1, 32'h300,
                        4'h1, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h300));
`ifdef CACHE_TO_CACHE_EN
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300,
                        4'h1, 4'h2, 0, 0, 1, 32'h300, 32'hAAAA, 1, 32'hAAAA, 0, 0, 32'h300));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300,
                        4'h1, 4'h2, 0, 0, 1, 32'h304, 32'hBBBB, 1, 32'hBBBB, 0, 0, 32'h300));
`else
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300,
                        4'h1, 4'h2, 0, 0, 1, 32'h300, 32'hAAAA, 0, 0, 0, 0, 32'h300));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300,
                        4'h1, 4'h2, 0, 0, 1, 32'h304, 32'hBBBB, 0, 0, 0, 0, 32'h300));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300,
                        4'h1, 0, 0, 1, 0, 32'h300, 0, 1, 32'h1000_0300, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300,
                        4'h1, 0, 0, 1, 0, 32'h304, 0, 1, 32'h1000_0304, 0, 0, 0));
`endif
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300,
                        4'h1, 0, 0, 0, 0, 0, 0, 0, 0, 1, SHARED, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 32'h300,
                        0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      @(posedge clk);
      #1 RST = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         vec_t v;
         v = vecs[i];
         req_valid = v.rv; req_write = v.rw; snoop_hit = v.hit; snoop_dirty = v.dirty;
         mem_ready = v.rdy; req_addr[0] = v.a0;
         @(negedge clk);
         check($sformatf("v%0d_ctl", i),
               {grant, snoop_req, snoop_inv, mem_ren, mem_wen, resp_valid, resp_done},
               {v.grant, v.sreq, v.sinv, v.ren, v.wen, v.rvalid, v.done});
         if (v.ren || v.wen) check($sformatf("v%0d_maddr", i), mem_addr, v.maddr);
         if (v.wen) check($sformatf("v%0d_wdata", i), {mem_wdata, snoop_idx},
                          {v.wdata, v.maddr[2]});
         if (v.rvalid) check($sformatf("v%0d_rdata", i), {resp_idx, resp_data},
                             {v.maddr[2], v.rdata});
         if (v.sreq != 0) check($sformatf("v%0d_saddr", i), snoop_addr, v.saddr);
         if (v.done) check($sformatf("v%0d_state", i), resp_state, v.st);
         step();
      end

      // Reset while stalled in the memory read: transaction dropped, no done
      snoop_hit = '0; snoop_dirty = '0; mem_ready = 1'b0;
      req_valid = 4'b0100;
      step();
      req_valid = '0;
      step();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("stall%0d", c), {grant, mem_ren, resp_valid, mem_addr},
               {4'b0100, 1'b1, 1'b0, 32'h400});
         step();
      end
      RST = 1'b1;
      step();
      RST = 1'b0;
      mem_ready = 1'b1;
      @(negedge clk);
      check_zero("abort");
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (resp_done) seen = 1'b1;
         @(negedge clk);
      end
      check("abort_no_done", seen, 1'b0);

      // Same cache requests again and is served normally
      #1 req_valid = 4'b0100;
      step();
      req_valid = '0;
      words = 0;
      seen  = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (resp_valid) begin
            check($sformatf("retry_w%0d", words), {resp_idx, resp_data},
                  {words[0], 32'h1000_0400 + 32'(words) * 4});
            words++;
         end
         if (resp_done) begin
            seen = 1'b1;
            check("retry_state", {grant, resp_state}, {4'b0100, EXCLUSIVE});
            break;
         end
      end
      check("retry_done", {seen, words}, {1'b1, 32'd2});

      // All four caches request continuously: grants rotate 0,1,2,3,0
      step();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      req_valid = 4'hF;
      mem_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << (k % 4);
         seen = 1'b0;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (grant != 0) begin
               seen = 1'b1;
               break;
            end
         end
         check($sformatf("rr_grant%0d", k), {seen, grant}, {1'b1, exp_g});
         seen = 1'b0;
         for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (resp_done) begin
               seen = 1'b1;
               break;
            end
         end
         check($sformatf("rr_done%0d", k), seen, 1'b1);
         @(negedge clk);
         check($sformatf("rr_gap%0d", k), grant, 4'b0000);
      end
      #1 req_valid = '0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
